// File: rtl/bmu_pkg.sv
// rtl/bmu_pkg.sv - shared types and constants for the BMU issue stage
// Purpose: decoded-op control word (bmu_ap_t) and BMU datapath widths.
// Ports: none (package).
package bmu_pkg;

  localparam int BMU_XLEN = 32;
  localparam int BMU_AP_W = 23;

  // Decoded BMU op, MSB -> LSB.
  typedef struct packed {
    logic csr_write;
    logic csr_imm;
    logic zbb;
    logic zbp;
    logic zba;
    logic zbs;
    logic land;
    logic lxor;
    logic sll;
    logic sra;
    logic rol;
    logic bext;
    logic sh3add;
    logic add;
    logic slt;
    logic unsign;
    logic sub;
    logic clz;
    logic cpop;
    logic siext_h;
    logic min;
    logic packu;
    logic gorc;
  } bmu_ap_t;

endpackage

// File: rtl/bmu_sync_fifo.sv
// rtl/bmu_sync_fifo.sv - single-clock FIFO used for the issue and result queues
// Purpose: DEPTH-entry first-word-fall-through FIFO; rdata is the head entry.
// Ports: clk, rst (sync, active-high, also used as a clear), push/wdata,
//        pop/rdata, count, full, empty. Push when full and pop when empty are ignored.
module bmu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are log2(DEPTH) bits so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bmu_issue_stage.sv
// rtl/bmu_issue_stage.sv - issue/return wrapper around the bit-manipulation unit
// Purpose: buffers decoded ops in an issue queue, feeds the BMU one op per cycle
//          while result-queue credit allows, captures the BMU result one cycle
//          later and returns it with its tag through a result queue.
// Ports: clk, rst (sync active-high), flush;
//        req_valid/req_ready/req_a/req_b/req_ap/req_csr_ren/req_csr_rddata/req_tag;
//        bmu_rst_l, bmu_valid_in, bmu_a_in, bmu_b_in, bmu_ap, bmu_csr_ren_in,
//        bmu_csr_rddata (to BMU); bmu_result_ff, bmu_error (from BMU);
//        rsp_valid/rsp_ready/rsp_data/rsp_error/rsp_tag; err_cnt.
module bmu_issue_stage
  import bmu_pkg::*;
#(
  parameter int IQ_DEPTH = 4,
  parameter int RQ_DEPTH = 4,
  parameter int TAG_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_a,
  input  logic [31:0]         req_b,
  input  bmu_ap_t             req_ap,
  input  logic                req_csr_ren,
  input  logic [31:0]         req_csr_rddata,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                bmu_rst_l,
  output logic                bmu_valid_in,
  output logic [31:0]         bmu_a_in,
  output logic [31:0]         bmu_b_in,
  output bmu_ap_t             bmu_ap,
  output logic                bmu_csr_ren_in,
  output logic [31:0]         bmu_csr_rddata,
  input  logic [31:0]         bmu_result_ff,
  input  logic                bmu_error,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic                rsp_error,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [7:0]          err_cnt
);

  localparam int IQ_W  = BMU_XLEN + BMU_XLEN + BMU_AP_W + 1 + BMU_XLEN + TAG_W;
  localparam int RQ_W  = BMU_XLEN + 1 + TAG_W;
  localparam int IQ_CW = $clog2(IQ_DEPTH) + 1;
  localparam int RQ_CW = $clog2(RQ_DEPTH) + 1;

  logic [IQ_W-1:0]     iq_wdata;
  logic [IQ_W-1:0]     iq_rdata;
  logic [IQ_CW-1:0]    iq_count;
  logic                iq_full;
  logic                iq_empty;
  logic                iq_push;

  logic [RQ_W-1:0]     rq_wdata;
  logic [RQ_W-1:0]     rq_rdata;
  logic [RQ_CW-1:0]    rq_count;
  logic                rq_full;
  logic                rq_empty;
  logic                rq_push;
  logic                rq_pop;

  logic [31:0]         h_a;
  logic [31:0]         h_b;
  bmu_ap_t             h_ap;
  logic                h_csr_ren;
  logic [31:0]         h_csr_rddata;
  logic [TAG_W-1:0]    h_tag;

  logic                infl;
  logic [TAG_W-1:0]    infl_tag;
  logic [RQ_CW:0]      credit_used;
  logic                issue_en;
  logic                unused_flags;

  assign unused_flags = &{1'b0, iq_full, rq_full};

  // Ready looks only at the registered count: a full queue stays not-ready
  // even in a cycle that pops it, keeping issue logic off the ready path.
  assign req_ready = !rst && (iq_count < IQ_CW'(IQ_DEPTH));
  assign iq_push   = req_valid && req_ready;
  assign iq_wdata  = {req_a, req_b, req_ap, req_csr_ren, req_csr_rddata, req_tag};
  assign {h_a, h_b, h_ap, h_csr_ren, h_csr_rddata, h_tag} = iq_rdata;

  // flush clears the issue queue at the edge, so a same-cycle push is dropped.
  bmu_sync_fifo #(.WIDTH(IQ_W), .DEPTH(IQ_DEPTH)) u_iq (
    .clk   (clk),
    .rst   (rst || flush),
    .push  (iq_push),
    .pop   (issue_en),
    .wdata (iq_wdata),
    .rdata (iq_rdata),
    .count (iq_count),
    .full  (iq_full),
    .empty (iq_empty)
  );

  // An issued op reserves a result slot until it lands; a same-cycle response
  // pop is deliberately not counted as freeing a slot.
  assign credit_used = {1'b0, rq_count} + {{RQ_CW{1'b0}}, infl};
  assign issue_en    = !rst && !flush && !iq_empty &&
                       (credit_used < (RQ_CW+1)'(RQ_DEPTH));

  always_comb begin
    bmu_valid_in   = 1'b0;
    bmu_a_in       = '0;
    bmu_b_in       = '0;
    bmu_ap         = '0;
    bmu_csr_ren_in = 1'b0;
    bmu_csr_rddata = '0;
    if (issue_en) begin
      bmu_valid_in   = 1'b1;
      bmu_a_in       = h_a;
      bmu_b_in       = h_b;
      bmu_ap         = h_ap;
      bmu_csr_ren_in = h_csr_ren;
      bmu_csr_rddata = h_csr_rddata;
    end
  end

  assign bmu_rst_l = ~rst;

  // Fixed one-cycle BMU latency: the op issued last cycle has its result now.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      infl     <= 1'b0;
      infl_tag <= '0;
    end else begin
      infl <= issue_en;
      if (issue_en) infl_tag <= h_tag;
    end
  end

  assign rq_push  = infl && !flush;
  assign rq_wdata = {bmu_result_ff, bmu_error, infl_tag};
  assign rq_pop   = rsp_valid && rsp_ready;

  bmu_sync_fifo #(.WIDTH(RQ_W), .DEPTH(RQ_DEPTH)) u_rq (
    .clk   (clk),
    .rst   (rst),
    .push  (rq_push),
    .pop   (rq_pop),
    .wdata (rq_wdata),
    .rdata (rq_rdata),
    .count (rq_count),
    .full  (rq_full),
    .empty (rq_empty)
  );

  assign rsp_valid = !rst && !rq_empty;
  assign {rsp_data, rsp_error, rsp_tag} = rq_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (rq_pop && rsp_error && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bmu_issue_stage.sv
// tb/tb_bmu_issue_stage.sv - directed self-checking bench for bmu_issue_stage
module tb_bmu_issue_stage;
  import bmu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  bmu_ap_t     req_ap;
  logic        req_csr_ren;
  logic [31:0] req_csr_rddata;
  logic [3:0]  req_tag;
  logic        bmu_rst_l;
  logic        bmu_valid_in;
  logic [31:0] bmu_a_in;
  logic [31:0] bmu_b_in;
  bmu_ap_t     bmu_ap;
  logic        bmu_csr_ren_in;
  logic [31:0] bmu_csr_rddata;
  logic [31:0] bmu_result_ff;
  logic        bmu_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [3:0]  rsp_tag;
  logic [7:0]  err_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int issue_cnt = 0;
  int first_iss = 0;
  int last_iss = 0;
  logic [3:0]  col_tag[$];
  logic [31:0] col_data[$];
  logic        col_err[$];

  bmu_issue_stage #(.IQ_DEPTH(4), .RQ_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_ap(req_ap), .req_csr_ren(req_csr_ren), .req_csr_rddata(req_csr_rddata),
    .req_tag(req_tag), .bmu_rst_l(bmu_rst_l), .bmu_valid_in(bmu_valid_in),
    .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in), .bmu_ap(bmu_ap),
    .bmu_csr_ren_in(bmu_csr_ren_in), .bmu_csr_rddata(bmu_csr_rddata),
    .bmu_result_ff(bmu_result_ff), .bmu_error(bmu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // BMU stand-in: one-cycle latency; add or xor; csr_write marks an error.
  always @(posedge clk) begin
    bmu_result_ff <= bmu_ap.add ? (bmu_a_in + bmu_b_in) : (bmu_a_in ^ bmu_b_in);
    bmu_error     <= bmu_ap.csr_write;
    cyc           <= cyc + 1;
  end

  // Inputs only change just after posedge, so negedge values hold through the next edge.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      col_tag.push_back(rsp_tag);
      col_data.push_back(rsp_data);
      col_err.push_back(rsp_error);
    end
    if (bmu_valid_in) begin
      if (issue_cnt == 0) first_iss = cyc;
      last_iss = cyc;
      issue_cnt++;
    end
  end

  task automatic clear_logs();
    col_tag.delete();
    col_data.delete();
    col_err.delete();
    issue_cnt = 0;
  endtask

  // Offers ops k = base..base+n-1 (tag k mod 16, a=k, b=3k, add) one per cycle.
  task automatic push_ops(input int base, input int n, input bit err, input int budget,
                          output int acc);
    int  spent;
    bit  ok;
    acc   = 0;
    spent = 0;
    while (acc < n && spent < budget) begin
      req_valid      = 1'b1;
      req_a          = 32'(base + acc);
      req_b          = 32'(3 * (base + acc));
      req_tag        = 4'((base + acc) % 16);
      req_ap         = '0;
      req_ap.add     = 1'b1;
      req_ap.csr_write = err;
      req_csr_ren    = 1'b0;
      req_csr_rddata = '0;
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
      if (ok) acc++;
      spent++;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_collect(input int n, input int budget);
    int spent = 0;
    while (col_tag.size() < n && spent < budget) begin
      @(negedge clk);
      spent++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if (req_ready !== 1'b0) begin $display("FAIL reset_req_ready: got %b expected 0", req_ready); miscompares++; end
    vectors++;
    if (rsp_valid !== 1'b0) begin $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); miscompares++; end
    vectors++;
    if (bmu_rst_l !== 1'b0) begin $display("FAIL reset_bmu_rst_l: got %b expected 0", bmu_rst_l); miscompares++; end
    vectors++;
    if (bmu_valid_in !== 1'b0) begin $display("FAIL reset_bmu_valid: got %b expected 0", bmu_valid_in); miscompares++; end
    vectors++;
    if (err_cnt !== 8'd0) begin $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); miscompares++; end
    vectors++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    if (req_ready !== 1'b1) begin $display("FAIL post_reset_req_ready: got %b expected 1", req_ready); miscompares++; end
    vectors++;
    if (bmu_rst_l !== 1'b1) begin $display("FAIL post_reset_bmu_rst_l: got %b expected 1", bmu_rst_l); miscompares++; end
    vectors++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    clear_logs();
    rsp_ready      = 1'b0;
    req_valid      = 1'b1;
    req_a          = 32'd5;
    req_b          = 32'd7;
    req_ap         = '0;
    req_ap.add     = 1'b1;
    req_csr_ren    = 1'b1;
    req_csr_rddata = 32'h0000CAFE;
    req_tag        = 4'd3;
    @(posedge clk); #1;                      // accept edge E0
    req_valid = 1'b0;
    @(negedge clk);
    if (bmu_valid_in !== 1'b1) begin $display("FAIL single_issue_valid: got %b expected 1", bmu_valid_in); miscompares++; end
    vectors++;
    if (bmu_a_in !== 32'd5 || bmu_b_in !== 32'd7) begin $display("FAIL single_operands: got a=%0d b=%0d expected a=5 b=7", bmu_a_in, bmu_b_in); miscompares++; end
    vectors++;
    if (bmu_ap.add !== 1'b1 || bmu_csr_ren_in !== 1'b1 || bmu_csr_rddata !== 32'h0000CAFE) begin
      $display("FAIL single_ctrl: got add=%b ren=%b rd=%h expected add=1 ren=1 rd=0000cafe", bmu_ap.add, bmu_csr_ren_in, bmu_csr_rddata); miscompares++;
    end
    vectors++;
    @(posedge clk); #1;                      // E1
    @(negedge clk);
    if (bmu_valid_in !== 1'b0 || bmu_a_in !== 32'd0) begin $display("FAIL single_idle_outputs: got valid=%b a=%0d expected valid=0 a=0", bmu_valid_in, bmu_a_in); miscompares++; end
    vectors++;
    if (rsp_valid !== 1'b0) begin $display("FAIL single_rsp_early: got %b expected 0", rsp_valid); miscompares++; end
    vectors++;
    @(posedge clk); #1;                      // E2
    @(negedge clk);
    if (rsp_valid !== 1'b1) begin $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); miscompares++; end
    vectors++;
    if (rsp_data !== 32'd12 || rsp_tag !== 4'd3 || rsp_error !== 1'b0) begin
      $display("FAIL single_rsp: got data=%0d tag=%0d err=%b expected data=12 tag=3 err=0", rsp_data, rsp_tag, rsp_error); miscompares++;
    end
    vectors++;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    if (rsp_valid !== 1'b0) begin $display("FAIL single_drained: got %b expected 0", rsp_valid); miscompares++; end
    vectors++;
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    int acc;
    clear_logs();
    rsp_ready = 1'b1;
    push_ops(0, 8, 1'b0, 20, acc);
    wait_collect(8, 30);
    if (acc !== 8) begin $display("FAIL burst_accepted: got %0d expected 8", acc); miscompares++; end
    vectors++;
    if (issue_cnt !== 8 || (last_iss - first_iss) !== 7) begin
      $display("FAIL burst_issue_rate: got %0d issues over %0d cycles expected 8 over 7", issue_cnt, last_iss - first_iss); miscompares++;
    end
    vectors++;
    if (col_tag.size() !== 8) begin $display("FAIL burst_count: got %0d expected 8", col_tag.size()); miscompares++; end
    vectors++;
    for (int i = 0; i < 8 && i < col_tag.size(); i++) begin
      if (col_tag[i] !== 4'(i) || col_data[i] !== 32'(4 * i)) begin
        $display("FAIL burst_rsp%0d: got tag=%0d data=%0d expected tag=%0d data=%0d", i, col_tag[i], col_data[i], i, 4 * i); miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_back_pressure();
    int acc;
    int acc2;
    clear_logs();
    rsp_ready = 1'b0;
    push_ops(0, 10, 1'b0, 12, acc);
    if (acc !== 8) begin $display("FAIL bp_accepted: got %0d expected 8", acc); miscompares++; end
    vectors++;
    @(negedge clk);
    if (issue_cnt !== 4) begin $display("FAIL bp_issued: got %0d expected 4", issue_cnt); miscompares++; end
    vectors++;
    if (req_ready !== 1'b0) begin $display("FAIL bp_req_ready: got %b expected 0", req_ready); miscompares++; end
    vectors++;
    if (bmu_valid_in !== 1'b0) begin $display("FAIL bp_bmu_valid: got %b expected 0", bmu_valid_in); miscompares++; end
    vectors++;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    push_ops(8, 2, 1'b0, 20, acc2);
    wait_collect(10, 40);
    if (acc2 !== 2) begin $display("FAIL bp_tail_accepted: got %0d expected 2", acc2); miscompares++; end
    vectors++;
    if (col_tag.size() !== 10) begin $display("FAIL bp_count: got %0d expected 10", col_tag.size()); miscompares++; end
    vectors++;
    for (int i = 0; i < 10 && i < col_tag.size(); i++) begin
      if (col_tag[i] !== 4'(i) || col_data[i] !== 32'(4 * i)) begin
        $display("FAIL bp_rsp%0d: got tag=%0d data=%0d expected tag=%0d data=%0d", i, col_tag[i], col_data[i], i, 4 * i); miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_flush();
    clear_logs();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid  = 1'b1;
      req_a      = 32'(3 + i);
      req_b      = 32'(3 * (3 + i));
      req_tag    = 4'(3 + i);
      req_ap     = '0;
      req_ap.add = 1'b1;
      flush      = (i == 4);
      if (i == 4) begin
        @(negedge clk);
        if (bmu_valid_in !== 1'b0) begin $display("FAIL flush_no_issue: got %b expected 0", bmu_valid_in); miscompares++; end
        vectors++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    idle(3);
    if (issue_cnt !== 3) begin $display("FAIL flush_issue_cnt: got %0d expected 3", issue_cnt); miscompares++; end
    vectors++;
    rsp_ready = 1'b1;
    wait_collect(2, 10);
    idle(6);
    if (col_tag.size() !== 2) begin $display("FAIL flush_count: got %0d expected 2", col_tag.size()); miscompares++; end
    vectors++;
    for (int i = 0; i < 2 && i < col_tag.size(); i++) begin
      if (col_tag[i] !== 4'(3 + i) || col_data[i] !== 32'(4 * (3 + i))) begin
        $display("FAIL flush_rsp%0d: got tag=%0d data=%0d expected tag=%0d data=%0d", i, col_tag[i], col_data[i], 3 + i, 4 * (3 + i)); miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_error_count();
    int acc;
    logic exp_err;
    clear_logs();
    rsp_ready = 1'b1;
    push_ops(0, 3, 1'b1, 10, acc);
    push_ops(3, 2, 1'b0, 10, acc);
    wait_collect(5, 20);
    if (col_tag.size() !== 5) begin $display("FAIL err_count_rsps: got %0d expected 5", col_tag.size()); miscompares++; end
    vectors++;
    for (int i = 0; i < 5 && i < col_err.size(); i++) begin
      exp_err = (i < 3);
      if (col_err[i] !== exp_err) begin $display("FAIL err_flag%0d: got %b expected %b", i, col_err[i], exp_err); miscompares++; end
      vectors++;
    end
    if (err_cnt !== 8'd3) begin $display("FAIL err_cnt_3: got %0d expected 3", err_cnt); miscompares++; end
    vectors++;
    push_ops(5, 300, 1'b1, 400, acc);
    wait_collect(305, 50);
    if (col_tag.size() !== 305) begin $display("FAIL err_bulk_rsps: got %0d expected 305", col_tag.size()); miscompares++; end
    vectors++;
    if (err_cnt !== 8'd255) begin $display("FAIL err_cnt_sat: got %0d expected 255", err_cnt); miscompares++; end
    vectors++;
  endtask

  task automatic test_reset_mid();
    int acc;
    clear_logs();
    rsp_ready = 1'b0;
    push_ops(0, 8, 1'b0, 12, acc);
    @(negedge clk);
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      $display("FAIL rstmid_pre: got rsp_valid=%b req_ready=%b expected 1 0", rsp_valid, req_ready); miscompares++;
    end
    vectors++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || bmu_rst_l !== 1'b0) begin
      $display("FAIL rstmid_outputs: got req_ready=%b rsp_valid=%b bmu_rst_l=%b expected 0 0 0", req_ready, rsp_valid, bmu_rst_l); miscompares++;
    end
    vectors++;
    if (err_cnt !== 8'd0) begin $display("FAIL rstmid_err_cnt: got %0d expected 0", err_cnt); miscompares++; end
    vectors++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      $display("FAIL rstmid_after: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid); miscompares++;
    end
    vectors++;
    @(posedge clk); #1;
    clear_logs();
    rsp_ready = 1'b1;
    push_ops(9, 1, 1'b0, 5, acc);
    wait_collect(1, 10);
    idle(4);
    if (col_tag.size() !== 1) begin $display("FAIL rstmid_count: got %0d expected 1", col_tag.size()); miscompares++; end
    vectors++;
    if (col_tag.size() > 0) begin
      if (col_tag[0] !== 4'd9 || col_data[0] !== 32'd36 || col_err[0] !== 1'b0) begin
        $display("FAIL rstmid_rsp: got tag=%0d data=%0d err=%b expected tag=9 data=36 err=0", col_tag[0], col_data[0], col_err[0]); miscompares++;
      end
      vectors++;
    end
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    req_valid      = 1'b0;
    req_a          = '0;
    req_b          = '0;
    req_ap         = '0;
    req_csr_ren    = 1'b0;
    req_csr_rddata = '0;
    req_tag        = '0;
    rsp_ready      = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_burst();
    test_back_pressure();
    test_flush();
    test_error_count();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
